// File: rtl/lane_block_scheduler_pkg.sv
// Game-wide constants shared by the lane scheduler and the block renderer,
// plus a small saturating-add helper for the score counters.
//   HW         height register width in pixels
//   LANE_NSLOT concurrent block slots per lane
//   H_TOP      height a block starts at when spawned
//   H_BOTTOM   off-screen height; also the parked height of an empty slot
//   HIT_LO/HI  inclusive hit window
package bnw_pkg;

  localparam int HW         = 10;
  localparam int LANE_NSLOT = 4;

  localparam logic [HW-1:0] H_TOP    = 10'd120;
  localparam logic [HW-1:0] H_BOTTOM = 10'd720;
  localparam logic [HW-1:0] HIT_LO   = 10'd600;
  localparam logic [HW-1:0] HIT_HI   = 10'd700;

  // Add a small increment to an 8-bit score, clamping at 255.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {5'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/lane_block_scheduler_if.sv
// Lane scheduler bus: control/beat/key strobes in, slot pool and score out.
// All inputs are level or one-cycle strobes sampled on the rising clock;
// there is no back-pressure: every strobe is consumed in the cycle it is
// high, and every output pulse is high for exactly one cycle.
//   master : game controller / beat counter / key debouncer side (drives inputs)
//   slave  : lane_block_scheduler
interface lane_block_scheduler_if
  import bnw_pkg::*;
#(
  parameter int NSLOT = LANE_NSLOT,
  parameter int W     = HW
);
  logic               restart;
  logic               pause;
  logic               tick;
  logic [6:0]         beat_cnt;
  logic               note_at_beat;
  logic               key_press;
  logic [NSLOT*W-1:0] block_h;
  logic [NSLOT-1:0]   slot_active;
  logic               hit_pulse;
  logic               miss_pulse;
  logic               wrong_pulse;
  logic               drop_pulse;
  logic [7:0]         hit_cnt;
  logic [7:0]         miss_cnt;

  modport master (
    output restart, pause, tick, beat_cnt, note_at_beat, key_press,
    input  block_h, slot_active, hit_pulse, miss_pulse, wrong_pulse,
           drop_pulse, hit_cnt, miss_cnt
  );

  modport slave (
    input  restart, pause, tick, beat_cnt, note_at_beat, key_press,
    output block_h, slot_active, hit_pulse, miss_pulse, wrong_pulse,
           drop_pulse, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/lane_slot_select.sv
// Combinational slot picker for one lane.
//   slot_active in  NSLOT      live-slot mask (pre-update values)
//   block_h     in  NSLOT*HW   packed slot heights
//   free_idx    out            lowest-index inactive slot
//   free_vld    out            at least one slot is free
//   hit_idx     out            active slot inside the hit window with the
//                              largest height; ties go to the lowest index
//   hit_vld     out            at least one slot is inside the hit window
module lane_slot_select
  import bnw_pkg::*;
#(
  parameter int NSLOT = LANE_NSLOT,
  parameter int IW    = $clog2(NSLOT)
) (
  input  logic [NSLOT-1:0]    slot_active,
  input  logic [NSLOT*HW-1:0] block_h,
  output logic [IW-1:0]       free_idx,
  output logic                free_vld,
  output logic [IW-1:0]       hit_idx,
  output logic                hit_vld
);

  logic [HW-1:0] best_h;
  logic [HW-1:0] cur_h;

  // Scan high to low so the last assignment is the lowest free index.
  always_comb begin
    free_vld = 1'b0;
    free_idx = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (!slot_active[i]) begin
        free_vld = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  // Scan low to high; only a strictly deeper block displaces the current
  // pick, which leaves ties with the lower index.
  always_comb begin
    hit_vld = 1'b0;
    hit_idx = '0;
    best_h  = '0;
    cur_h   = '0;
    for (int i = 0; i < NSLOT; i++) begin
      cur_h = block_h[i*HW +: HW];
      if (slot_active[i] && cur_h >= HIT_LO && cur_h <= HIT_HI &&
          (!hit_vld || cur_h > best_h)) begin
        hit_vld = 1'b1;
        hit_idx = IW'(i);
        best_h  = cur_h;
      end
    end
  end

endmodule

// File: rtl/lane_block_scheduler.sv
// Falling-block pool for one piano lane: spawns blocks on charted beat edges,
// advances them on frame ticks, retires them on a hit or at the bottom, and
// keeps saturating hit/miss scores. All outputs are registered (1-cycle latency).
//   clk    in  system clock
//   rst_n  in  synchronous active-low reset
//   bus    slave modport of lane_block_scheduler_if (strobes in, pool/score out)
module lane_block_scheduler
  import bnw_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  lane_block_scheduler_if.slave  bus
);

  localparam int NSLOT = LANE_NSLOT;
  localparam int IW    = $clog2(NSLOT);

  logic [HW-1:0]       h_q [NSLOT];
  logic [HW-1:0]       h_d [NSLOT];
  logic [NSLOT-1:0]    act_q, act_d;
  logic [NSLOT*HW-1:0] h_flat;
  logic [6:0]          pre_beat_q;
  logic                hit_pulse_q, miss_pulse_q, wrong_pulse_q, drop_pulse_q;
  logic [7:0]          hit_cnt_q, miss_cnt_q;

  logic [IW-1:0]       free_idx, hit_idx;
  logic                free_vld, hit_vld;
  logic                spawn_ev, key_ev, adv_ev;
  logic [NSLOT-1:0]    spawn_sel, hit_sel;
  logic [3:0]          n_miss;

  for (genvar g = 0; g < NSLOT; g++) begin : g_pack
    assign h_flat[g*HW +: HW] = h_q[g];
  end

  lane_slot_select #(.NSLOT(NSLOT), .IW(IW)) u_select (
    .slot_active (act_q),
    .block_h     (h_flat),
    .free_idx    (free_idx),
    .free_vld    (free_vld),
    .hit_idx     (hit_idx),
    .hit_vld     (hit_vld)
  );

  // Only a strictly increasing beat number spawns, so a chart restart or
  // counter wrap never injects a block.
  assign spawn_ev = (bus.beat_cnt > pre_beat_q) && bus.note_at_beat && !bus.pause;
  assign key_ev   = bus.key_press && !bus.pause;
  assign adv_ev   = bus.tick && !bus.pause;

  // Selections come from pre-cycle state: the spawn target is inactive, so it
  // can never be the hit target, and a slot freed this cycle stays empty.
  assign spawn_sel = (spawn_ev && free_vld) ? (NSLOT'(1) << free_idx) : '0;
  assign hit_sel   = (key_ev && hit_vld)    ? (NSLOT'(1) << hit_idx)  : '0;

  always_comb begin
    act_d  = act_q;
    n_miss = '0;
    for (int i = 0; i < NSLOT; i++) begin
      h_d[i] = h_q[i];
      if (spawn_sel[i]) begin
        h_d[i]   = H_TOP;
        act_d[i] = 1'b1;
      end else if (hit_sel[i]) begin
        h_d[i]   = H_BOTTOM;
        act_d[i] = 1'b0;
      end else if (adv_ev && act_q[i]) begin
        if (h_q[i] + HW'(1) == H_BOTTOM) begin
          h_d[i]   = H_BOTTOM;
          act_d[i] = 1'b0;
          n_miss   = n_miss + 4'd1;
        end else begin
          h_d[i] = h_q[i] + HW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bus.restart) begin
      for (int i = 0; i < NSLOT; i++) h_q[i] <= H_BOTTOM;
      act_q         <= '0;
      pre_beat_q    <= '0;
      hit_pulse_q   <= 1'b0;
      miss_pulse_q  <= 1'b0;
      wrong_pulse_q <= 1'b0;
      drop_pulse_q  <= 1'b0;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
    end else begin
      for (int i = 0; i < NSLOT; i++) h_q[i] <= h_d[i];
      act_q         <= act_d;
      pre_beat_q    <= bus.beat_cnt;
      hit_pulse_q   <= key_ev && hit_vld;
      wrong_pulse_q <= key_ev && !hit_vld;
      drop_pulse_q  <= spawn_ev && !free_vld;
      miss_pulse_q  <= (n_miss != 4'd0);
      hit_cnt_q     <= sat_add8(hit_cnt_q, {3'b0, key_ev && hit_vld});
      miss_cnt_q    <= sat_add8(miss_cnt_q, n_miss);
    end
  end

  assign bus.block_h     = h_flat;
  assign bus.slot_active = act_q;
  assign bus.hit_pulse   = hit_pulse_q;
  assign bus.miss_pulse  = miss_pulse_q;
  assign bus.wrong_pulse = wrong_pulse_q;
  assign bus.drop_pulse  = drop_pulse_q;
  assign bus.hit_cnt     = hit_cnt_q;
  assign bus.miss_cnt    = miss_cnt_q;

endmodule

// File: tb/tb_lane_block_scheduler.sv
// Directed bench for lane_block_scheduler. Inputs change on the falling edge;
// outputs are inspected on the following falling edge, after the rising edge
// that consumed them.
module tb_lane_block_scheduler;
  import bnw_pkg::*;

  localparam int NS = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  lane_block_scheduler_if bus_if ();

  lane_block_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  function automatic logic [NS*HW-1:0] hv(input int h0, input int h1, input int h2, input int h3);
    return {HW'(h3), HW'(h2), HW'(h1), HW'(h0)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n               = 1'b0;
    bus_if.restart      = 1'b0;
    bus_if.pause        = 1'b0;
    bus_if.tick         = 1'b0;
    bus_if.beat_cnt     = 7'd0;
    bus_if.note_at_beat = 1'b0;
    bus_if.key_press    = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
  endtask

  task automatic beat_spawn();
    bus_if.beat_cnt     = bus_if.beat_cnt + 7'd1;
    bus_if.note_at_beat = 1'b1;
    cyc();
    bus_if.note_at_beat = 1'b0;
  endtask

  task automatic ticks(input int n);
    bus_if.tick = 1'b1;
    repeat (n) cyc();
    bus_if.tick = 1'b0;
  endtask

  task automatic key_hit();
    bus_if.key_press = 1'b1;
    cyc();
    bus_if.key_press = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (bus_if.block_h !== hv(720, 720, 720, 720)) begin failures++; $display("FAIL reset_h got=%h exp=%h", bus_if.block_h, hv(720, 720, 720, 720)); end
    checks++; if (bus_if.slot_active !== 4'b0000) begin failures++; $display("FAIL reset_active got=%b exp=0000", bus_if.slot_active); end
    checks++; if ({bus_if.hit_cnt, bus_if.miss_cnt} !== 16'h0000) begin failures++; $display("FAIL reset_cnt got=%h exp=0000", {bus_if.hit_cnt, bus_if.miss_cnt}); end
    checks++; if ({bus_if.hit_pulse, bus_if.miss_pulse, bus_if.wrong_pulse, bus_if.drop_pulse} !== 4'b0000) begin failures++; $display("FAIL reset_pulses got=%b exp=0000", {bus_if.hit_pulse, bus_if.miss_pulse, bus_if.wrong_pulse, bus_if.drop_pulse}); end
    // Mid-game restart: two blocks in flight plus a wrong press scored.
    beat_spawn();
    ticks(5);
    beat_spawn();
    key_hit();
    bus_if.restart = 1'b1;
    cyc();
    bus_if.restart = 1'b0;
    checks++; if (bus_if.block_h !== hv(720, 720, 720, 720)) begin failures++; $display("FAIL restart_h got=%h exp=%h", bus_if.block_h, hv(720, 720, 720, 720)); end
    checks++; if (bus_if.slot_active !== 4'b0000) begin failures++; $display("FAIL restart_active got=%b exp=0000", bus_if.slot_active); end
    checks++; if (bus_if.wrong_pulse !== 1'b0) begin failures++; $display("FAIL restart_wrong got=%b exp=0", bus_if.wrong_pulse); end
  endtask

  task automatic test_spawn_fall();
    int seen;
    do_reset();
    bus_if.beat_cnt = 7'd5;
    cyc();
    beat_spawn();
    checks++; if (bus_if.slot_active !== 4'b0001) begin failures++; $display("FAIL spawn_active got=%b exp=0001", bus_if.slot_active); end
    checks++; if (bus_if.block_h !== hv(120, 720, 720, 720)) begin failures++; $display("FAIL spawn_h got=%h exp=%h", bus_if.block_h, hv(120, 720, 720, 720)); end
    seen = 0;
    bus_if.tick = 1'b1;
    for (int k = 0; k < 599; k++) begin
      cyc();
      if (bus_if.miss_pulse === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL fall_early_miss got=%0d exp=0", seen); end
    checks++; if (bus_if.block_h !== hv(719, 720, 720, 720)) begin failures++; $display("FAIL fall_719 got=%h exp=%h", bus_if.block_h, hv(719, 720, 720, 720)); end
    cyc();
    bus_if.tick = 1'b0;
    checks++; if (bus_if.miss_pulse !== 1'b1) begin failures++; $display("FAIL fall_miss_pulse got=%b exp=1", bus_if.miss_pulse); end
    checks++; if (bus_if.miss_cnt !== 8'd1) begin failures++; $display("FAIL fall_miss_cnt got=%0d exp=1", bus_if.miss_cnt); end
    checks++; if (bus_if.slot_active !== 4'b0000 || bus_if.block_h !== hv(720, 720, 720, 720)) begin failures++; $display("FAIL fall_freed got=%b/%h exp=0000/%h", bus_if.slot_active, bus_if.block_h, hv(720, 720, 720, 720)); end
    cyc();
    checks++; if (bus_if.miss_pulse !== 1'b0) begin failures++; $display("FAIL fall_pulse_once got=%b exp=0", bus_if.miss_pulse); end
  endtask

  task automatic test_hit();
    do_reset();
    beat_spawn();
    ticks(530);
    checks++; if (bus_if.block_h !== hv(650, 720, 720, 720)) begin failures++; $display("FAIL hit_pre_h got=%h exp=%h", bus_if.block_h, hv(650, 720, 720, 720)); end
    key_hit();
    checks++; if ({bus_if.hit_pulse, bus_if.wrong_pulse} !== 2'b10) begin failures++; $display("FAIL hit_pulse got=%b exp=10", {bus_if.hit_pulse, bus_if.wrong_pulse}); end
    checks++; if (bus_if.hit_cnt !== 8'd1) begin failures++; $display("FAIL hit_cnt got=%0d exp=1", bus_if.hit_cnt); end
    checks++; if (bus_if.slot_active !== 4'b0000 || bus_if.block_h !== hv(720, 720, 720, 720)) begin failures++; $display("FAIL hit_freed got=%b/%h exp=0000/%h", bus_if.slot_active, bus_if.block_h, hv(720, 720, 720, 720)); end
    beat_spawn();
    ticks(479);
    checks++; if (bus_if.block_h !== hv(599, 720, 720, 720)) begin failures++; $display("FAIL wrong_pre_h got=%h exp=%h", bus_if.block_h, hv(599, 720, 720, 720)); end
    key_hit();
    checks++; if ({bus_if.hit_pulse, bus_if.wrong_pulse} !== 2'b01) begin failures++; $display("FAIL wrong_pulse got=%b exp=01", {bus_if.hit_pulse, bus_if.wrong_pulse}); end
    checks++; if (bus_if.block_h !== hv(599, 720, 720, 720) || bus_if.slot_active !== 4'b0001 || bus_if.hit_cnt !== 8'd1) begin failures++; $display("FAIL wrong_state got=%h/%b/%0d exp=%h/0001/1", bus_if.block_h, bus_if.slot_active, bus_if.hit_cnt, hv(599, 720, 720, 720)); end
  endtask

  task automatic test_tie();
    do_reset();
    beat_spawn();
    beat_spawn();
    ticks(530);
    key_hit();
    checks++; if (bus_if.slot_active !== 4'b0010 || bus_if.block_h !== hv(720, 650, 720, 720)) begin failures++; $display("FAIL tie_low_index got=%b/%h exp=0010/%h", bus_if.slot_active, bus_if.block_h, hv(720, 650, 720, 720)); end
  endtask

  task automatic test_deepest();
    do_reset();
    beat_spawn();
    ticks(30);
    beat_spawn();
    ticks(530);
    beat_spawn();
    ticks(1);
    key_hit();
    beat_spawn();
    key_hit();
    ticks(500);
    checks++; if (bus_if.block_h !== hv(620, 720, 621, 720)) begin failures++; $display("FAIL deep_pre_h got=%h exp=%h", bus_if.block_h, hv(620, 720, 621, 720)); end
    key_hit();
    checks++; if (bus_if.block_h !== hv(620, 720, 720, 720) || bus_if.slot_active !== 4'b0001) begin failures++; $display("FAIL deep_pick got=%h/%b exp=%h/0001", bus_if.block_h, bus_if.slot_active, hv(620, 720, 720, 720)); end
    checks++; if (bus_if.hit_cnt !== 8'd3) begin failures++; $display("FAIL deep_hit_cnt got=%0d exp=3", bus_if.hit_cnt); end
  endtask

  task automatic test_overflow();
    do_reset();
    repeat (4) beat_spawn();
    checks++; if (bus_if.slot_active !== 4'b1111 || bus_if.block_h !== hv(120, 120, 120, 120)) begin failures++; $display("FAIL ovf_full got=%b/%h exp=1111/%h", bus_if.slot_active, bus_if.block_h, hv(120, 120, 120, 120)); end
    checks++; if (bus_if.drop_pulse !== 1'b0) begin failures++; $display("FAIL ovf_no_drop got=%b exp=0", bus_if.drop_pulse); end
    beat_spawn();
    checks++; if (bus_if.drop_pulse !== 1'b1) begin failures++; $display("FAIL ovf_drop got=%b exp=1", bus_if.drop_pulse); end
    checks++; if (bus_if.slot_active !== 4'b1111 || bus_if.block_h !== hv(120, 120, 120, 120)) begin failures++; $display("FAIL ovf_unchanged got=%b/%h exp=1111/%h", bus_if.slot_active, bus_if.block_h, hv(120, 120, 120, 120)); end
    cyc();
    checks++; if (bus_if.drop_pulse !== 1'b0) begin failures++; $display("FAIL ovf_drop_once got=%b exp=0", bus_if.drop_pulse); end
  endtask

  task automatic test_multi_miss();
    do_reset();
    beat_spawn();
    beat_spawn();
    ticks(600);
    checks++; if (bus_if.miss_pulse !== 1'b1 || bus_if.miss_cnt !== 8'd2) begin failures++; $display("FAIL multi_miss got=%b/%0d exp=1/2", bus_if.miss_pulse, bus_if.miss_cnt); end
    checks++; if (bus_if.slot_active !== 4'b0000) begin failures++; $display("FAIL multi_miss_free got=%b exp=0000", bus_if.slot_active); end
  endtask

  task automatic test_same_cycle_and_pause();
    do_reset();
    beat_spawn();
    ticks(10);
    beat_spawn();
    ticks(580);
    checks++; if (bus_if.block_h !== hv(710, 700, 720, 720)) begin failures++; $display("FAIL same_pre_h got=%h exp=%h", bus_if.block_h, hv(710, 700, 720, 720)); end
    bus_if.key_press    = 1'b1;
    bus_if.tick         = 1'b1;
    bus_if.beat_cnt     = bus_if.beat_cnt + 7'd1;
    bus_if.note_at_beat = 1'b1;
    cyc();
    bus_if.key_press    = 1'b0;
    bus_if.tick         = 1'b0;
    bus_if.note_at_beat = 1'b0;
    checks++; if (bus_if.block_h !== hv(711, 720, 120, 720)) begin failures++; $display("FAIL same_h got=%h exp=%h", bus_if.block_h, hv(711, 720, 120, 720)); end
    checks++; if (bus_if.slot_active !== 4'b0101) begin failures++; $display("FAIL same_active got=%b exp=0101", bus_if.slot_active); end
    checks++; if ({bus_if.hit_pulse, bus_if.miss_pulse, bus_if.wrong_pulse, bus_if.drop_pulse} !== 4'b1000 || bus_if.hit_cnt !== 8'd1) begin failures++; $display("FAIL same_pulses got=%b/%0d exp=1000/1", {bus_if.hit_pulse, bus_if.miss_pulse, bus_if.wrong_pulse, bus_if.drop_pulse}, bus_if.hit_cnt); end
    // Pause: tick, beat edge with a note and a key press all ignored.
    bus_if.pause        = 1'b1;
    bus_if.tick         = 1'b1;
    bus_if.key_press    = 1'b1;
    bus_if.beat_cnt     = bus_if.beat_cnt + 7'd1;
    bus_if.note_at_beat = 1'b1;
    cyc();
    bus_if.tick      = 1'b0;
    bus_if.key_press = 1'b0;
    checks++; if (bus_if.block_h !== hv(711, 720, 120, 720) || bus_if.slot_active !== 4'b0101) begin failures++; $display("FAIL pause_hold got=%h/%b exp=%h/0101", bus_if.block_h, bus_if.slot_active, hv(711, 720, 120, 720)); end
    checks++; if ({bus_if.hit_pulse, bus_if.miss_pulse, bus_if.wrong_pulse, bus_if.drop_pulse} !== 4'b0000 || bus_if.hit_cnt !== 8'd1 || bus_if.miss_cnt !== 8'd0) begin failures++; $display("FAIL pause_quiet got=%b/%0d/%0d exp=0000/1/0", {bus_if.hit_pulse, bus_if.miss_pulse, bus_if.wrong_pulse, bus_if.drop_pulse}, bus_if.hit_cnt, bus_if.miss_cnt); end
    cyc();
    bus_if.pause = 1'b0;
    cyc();
    bus_if.note_at_beat = 1'b0;
    checks++; if (bus_if.slot_active !== 4'b0101 || bus_if.block_h !== hv(711, 720, 120, 720) || bus_if.drop_pulse !== 1'b0) begin failures++; $display("FAIL unpause_no_spawn got=%b/%h exp=0101/%h", bus_if.slot_active, bus_if.block_h, hv(711, 720, 120, 720)); end
  endtask

  task automatic test_beat_wrap();
    do_reset();
    bus_if.beat_cnt = 7'd100;
    cyc();
    bus_if.beat_cnt     = 7'd3;
    bus_if.note_at_beat = 1'b1;
    cyc();
    bus_if.note_at_beat = 1'b0;
    checks++; if (bus_if.slot_active !== 4'b0000 || bus_if.drop_pulse !== 1'b0) begin failures++; $display("FAIL wrap_no_spawn got=%b/%b exp=0000/0", bus_if.slot_active, bus_if.drop_pulse); end
  endtask

  initial begin
    test_reset();
    test_spawn_fall();
    test_hit();
    test_tie();
    test_deepest();
    test_overflow();
    test_multi_miss();
    test_same_cycle_and_pause();
    test_beat_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
